// File: rtl/mem_responder.sv
// mem_responder: memory-interface target for the SLC-3 core.
// It holds DEPTH words of on-chip RAM and one MMIO word at MMIO_ADDR. Reads of
// that word return the synchronized switches, and writes to it load the hex
// display register. Requests use a level-valid/ready-pulse handshake. Writes
// complete in 1 cycle and reads in READ_LAT cycles.
// Optional feature: define MEM_RESP_WPROT_EN to drop RAM writes below
// PROT_LIMIT and raise a sticky prot_err_o flag.
module mem_responder #(
    parameter int          DEPTH      = 1024,
    parameter int          READ_LAT   = 2,
    parameter logic [15:0] MMIO_ADDR  = 16'hFFFF
`ifdef MEM_RESP_WPROT_EN
    ,
    parameter logic [15:0] PROT_LIMIT = 16'h0040
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_mem_ena,
    input  logic        mem_wr_ena,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    input  logic [15:0] sw_i,
    output logic [15:0] hex_o,
    output logic        prot_err_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [15:0]        addr_r;
    logic [15:0]        sw_cap_r;
    logic [15:0]        sw_meta_r;
    logic [15:0]        sw_sync_r;
    logic [15:0]        rdata_r;
    logic               ready_r;
    logic [15:0]        hex_r;
    logic [15:0]        ram_r [DEPTH];

    logic               accept_s;
    logic               mmio_s;
    logic               prot_hit_s;
    logic               wr_ram_s;
    logic               wr_hex_s;
    logic [15:0]        rd_addr_s;
    logic [15:0]        rd_sw_s;
    logic               load_rdata_s;

    assign mem_rdata = rdata_r;
    assign mem_ready = ready_r;
    assign hex_o     = hex_r;

    // State register, latency counter, request capture and the ready pulse.
    // ready_r mirrors "next state is DONE", so a reset during BUSY never
    // produces a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            addr_r   <= 16'h0000;
            sw_cap_r <= 16'h0000;
            ready_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ST_DONE);
            if (accept_s) begin
                cnt_r    <= CNT_W'(READ_LAT - 1);
                addr_r   <= mem_addr;
                sw_cap_r <= sw_sync_r;
            end else if ((state_r == ST_BUSY) && (cnt_r != '0)) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next-state logic. BUSY is left when the counter is about to expire,
    // so the DONE cycle lands exactly READ_LAT cycles after acceptance.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_mem_ena) begin
                    if (mem_wr_ena || (READ_LAT <= 1)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_BUSY;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r <= CNT_W'(1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath controls. In IDLE the live request is used, because a
    // single-cycle read completes on its own acceptance edge. In BUSY the
    // captured copy is used.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && mem_mem_ena;
        mmio_s   = (mem_addr == MMIO_ADDR);
`ifdef MEM_RESP_WPROT_EN
        prot_hit_s = !mmio_s && (mem_addr < PROT_LIMIT);
`else
        prot_hit_s = 1'b0;
`endif
        wr_ram_s  = accept_s && mem_wr_ena && !mmio_s && !prot_hit_s;
        wr_hex_s  = accept_s && mem_wr_ena && mmio_s;
        if (state_r == ST_IDLE) begin
            rd_addr_s = mem_addr;
            rd_sw_s   = sw_sync_r;
        end else begin
            rd_addr_s = addr_r;
            rd_sw_s   = sw_cap_r;
        end
        load_rdata_s = (state_s == ST_DONE) && !(accept_s && mem_wr_ena);
    end

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta_r <= 16'h0000;
            sw_sync_r <= 16'h0000;
        end else begin
            sw_meta_r <= sw_i;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Read data register. It updates on the edge entering DONE for reads
    // and holds until the next read completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= 16'h0000;
        end else if (load_rdata_s) begin
            if (rd_addr_s == MMIO_ADDR) begin
                rdata_r <= rd_sw_s;
            end else begin
                rdata_r <= ram_r[rd_addr_s[ADDR_W-1:0]];
            end
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // MMIO hex display register, loaded on the acceptance edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_r <= 16'h0000;
        end else if (wr_hex_s) begin
            hex_r <= mem_wdata;
        end else begin
            hex_r <= hex_r;
        end
    end

`ifdef MEM_RESP_WPROT_EN
    logic prot_err_r;
    assign prot_err_o = prot_err_r;

    // Sticky flag for RAM writes dropped by the protection window.
    always_ff @(posedge clk) begin
        if (reset) begin
            prot_err_r <= 1'b0;
        end else if (accept_s && mem_wr_ena && prot_hit_s) begin
            prot_err_r <= 1'b1;
        end else begin
            prot_err_r <= prot_err_r;
        end
    end
`else
    assign prot_err_o = 1'b0;
`endif

    // RAM storage. It is deliberately not cleared by reset, and it is
    // written on the acceptance edge. Upper address bits alias.
    always_ff @(posedge clk) begin
        if (!reset && wr_ram_s) begin
            ram_r[mem_addr[ADDR_W-1:0]] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (DEPTH=1024, READ_LAT=3).
// The driver issues one request at a time and records the expected response
// from a word-array model. An independent monitor checks each mem_ready pulse.
module tb_mem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    logic [15:0] rdata;
    logic        ready;
    logic [15:0] hex;
    logic        prot;

    mem_responder #(.DEPTH(1024), .READ_LAT(LAT), .MMIO_ADDR(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .mem_mem_ena(ena), .mem_wr_ena(wr),
        .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rdata), .mem_ready(ready),
        .sw_i(sw), .hex_o(hex), .prot_err_o(prot)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_rd;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;

    logic [15:0] mem_m [int];
    int          widx[$];
    logic [15:0] hex_m = 16'h0000;
    bit          prot_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Monitor: every ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", 32'(cyc), 32'(e.due));
                if (e.is_rd) chk("rdata", {16'h0, rdata}, {16'h0, e.data});
                chk("hex_o", {16'h0, hex}, {16'h0, hex_m});
                chk("prot_err", {31'h0, prot}, {31'h0, prot_m});
            end
        end
    end

    // Issue one request, update the model, and wait (bounded) for ready.
    // Inputs are scrambled while the request is in flight; the DUT must ignore them.
    task automatic do_req(input bit w, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        int   idx;
        bit   mm;
        bit   got;
        idx = int'(a[9:0]);
        mm  = (a == 16'hFFFF);
        @(negedge clk);
        ena = 1'b1; wr = w; addr = a; wdata = d;
        e.is_rd = !w;
        e.due   = cyc + (w ? 1 : LAT);
        e.data  = 16'h0000;
        if (w) begin
            if (mm) hex_m = d;
`ifdef MEM_RESP_WPROT_EN
            else if (a < 16'h0040) prot_m = 1'b1;
`endif
            else begin
                if (!mem_m.exists(idx)) widx.push_back(idx);
                mem_m[idx] = d;
            end
        end else begin
            e.data = mm ? sw : mem_m[idx];
        end
        sb.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            addr = 16'($urandom); wdata = 16'($urandom); wr = 1'($urandom);
        end
        ena = 1'b0;
        checks++;
        if (got) passes++;
        else begin
            $display("FAIL ready_timeout: got no ready expected ready within 20 cycles (addr %h)", a);
            if (sb.size() > 0) void'(sb.pop_back());
        end
    endtask

    initial begin
        logic [15:0] a;
        int          r;
        int          idx;
        reset = 1'b1; ena = 1'b0; wr = 1'b0; addr = 16'h0; wdata = 16'h0; sw = 16'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", {31'h0, ready}, 32'd0);
        chk("reset_rdata", {16'h0, rdata}, 32'd0);
        chk("reset_hex", {16'h0, hex}, 32'd0);
        chk("reset_prot", {31'h0, prot}, 32'd0);

        // Write then read back with full read latency.
        do_req(1'b1, 16'h0010, 16'h1234);
        do_req(1'b0, 16'h0010, 16'h0000);

        // MMIO: switches readable, hex writable, aliased RAM word untouched.
        do_req(1'b1, 16'h03FF, 16'h0C0D);
        sw = 16'h00A5;
        repeat (3) @(negedge clk);
        do_req(1'b0, 16'hFFFF, 16'h0000);
        do_req(1'b1, 16'hFFFF, 16'hBEEF);
        do_req(1'b0, 16'h03FF, 16'h0000);
        do_req(1'b0, 16'h0010, 16'h0000);

        // Reset during BUSY: no pulse, outputs cleared, RAM kept.
        @(negedge clk);
        ena = 1'b1; wr = 1'b0; addr = 16'h0010;
        @(negedge clk);
        ena = 1'b0; reset = 1'b1; addr = 16'h0020;
        @(negedge clk);
        reset = 1'b0;
        hex_m = 16'h0000; prot_m = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_reset_rdata", {16'h0, rdata}, 32'd0);
        chk("post_reset_hex", {16'h0, hex}, 32'd0);
        do_req(1'b0, 16'h0010, 16'h0000);

        // Aliasing modulo DEPTH.
        do_req(1'b1, 16'h0400, 16'h5555);
        do_req(1'b0, 16'h0000, 16'h0000);

        // Protection window boundary (model decides whether writes commit).
        do_req(1'b1, 16'h0420, 16'h1111);
        do_req(1'b1, 16'h0020, 16'h7777);
        do_req(1'b0, 16'h0020, 16'h0000);
        do_req(1'b1, 16'h0040, 16'h4040);
        do_req(1'b0, 16'h0040, 16'h0000);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_req(1'b1, 16'hFFFF, 16'($urandom));
            end else if (r == 1) begin
                sw = 16'($urandom);
                repeat (3) @(negedge clk);
                do_req(1'b0, 16'hFFFF, 16'h0000);
            end else if (r <= 4) begin
                a = 16'($urandom);
                if (a == 16'hFFFF) a = 16'h0000;
                do_req(1'b1, a, 16'($urandom));
            end else begin
                idx = widx[$urandom_range(0, widx.size() - 1)];
                a = 16'(($urandom_range(0, 62) << 10) | idx);
                do_req(1'b0, a, 16'h0000);
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
